// File: rtl/ysyx_22040237_ifu_fetch_ctrl_if.sv
// Signal bundle of the instruction fetch controller: pc source, instruction-memory
// request/response port and the core-side instruction port.
interface ysyx_22040237_ifu_fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic [ADDR_W-1:0] pc_i;
   logic              pc_valid_i;
   logic              flush_i;

   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic              mem_resp_valid_i;
   logic [INST_W-1:0] mem_resp_data_i;
   logic              mem_resp_err_i;

   logic              inst_valid_o;
   logic [INST_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_pc_o;
   logic              inst_ready_i;
   logic              fetch_err_o;
   logic              fetch_misalign_o;
   logic              busy_o;

   modport master (
      input  pc_i, pc_valid_i, flush_i,
      output mem_req_valid_o, mem_req_addr_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
      output inst_valid_o, inst_o, inst_pc_o, fetch_err_o, fetch_misalign_o, busy_o,
      input  inst_ready_i
   );

   modport slave (
      output pc_i, pc_valid_i, flush_i,
      input  mem_req_valid_o, mem_req_addr_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
      input  inst_valid_o, inst_o, inst_pc_o, fetch_err_o, fetch_misalign_o, busy_o,
      output inst_ready_i
   );
endinterface

// File: rtl/ysyx_22040237_ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller feeding the core's instruction input.
// Optional response watchdog enabled by defining FETCH_TIMEOUT_EN.
module ysyx_22040237_ifu_fetch_ctrl #(
   parameter int                ADDR_W      = 32,
   parameter int                INST_W      = 32,
   parameter logic [INST_W-1:0] NOP_INST    = INST_W'(32'h00000013),
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   ysyx_22040237_ifu_fetch_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN,
      HOLD
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic              drop;
   logic              req_valid;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              err;
   logic              misalign;
   logic              busy;
   logic              late_block;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] wdog;
   logic       late_pending;

   // A timed-out request may still answer; no new request until that answer is swallowed.
   assign late_block = late_pending;
`else
   logic timeout_unused;

   assign timeout_unused = (TIMEOUT_CYC != 0);
   assign late_block     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         drop       <= 1'b0;
         req_valid  <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= NOP_INST;
         inst_pc    <= '0;
         err        <= 1'b0;
         misalign   <= 1'b0;
         busy       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wdog         <= '0;
         late_pending <= 1'b0;
`endif
      end else begin
`ifdef FETCH_TIMEOUT_EN
         if (late_pending && bus.mem_resp_valid_i) begin
            late_pending <= 1'b0;
         end
`endif
         case (state)
            IDLE: begin
               if (bus.pc_valid_i && !bus.flush_i && !late_block) begin
                  addr <= bus.pc_i;
                  busy <= 1'b1;
                  if (bus.pc_i[1:0] == 2'b00) begin
                     state     <= REQ;
                     req_valid <= 1'b1;
                  end else begin
                     // Misaligned pc never reaches memory; hand the core a NOP instead.
                     state      <= HOLD;
                     inst       <= NOP_INST;
                     inst_pc    <= bus.pc_i;
                     err        <= 1'b0;
                     misalign   <= 1'b1;
                     inst_valid <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (bus.mem_req_ready_i) begin
                  req_valid <= 1'b0;
                  drop      <= 1'b0;
                  if (drop || bus.flush_i) begin
                     state <= DRAIN;
                  end else begin
                     state <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                     wdog  <= '0;
`endif
                  end
               end else if (bus.flush_i) begin
                  // The request cannot be withdrawn, so remember to discard its answer.
                  drop <= 1'b1;
               end
            end

            WAIT: begin
               if (bus.mem_resp_valid_i) begin
                  if (bus.flush_i) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state      <= HOLD;
                     inst       <= bus.mem_resp_err_i ? NOP_INST : bus.mem_resp_data_i;
                     inst_pc    <= addr;
                     err        <= bus.mem_resp_err_i;
                     misalign   <= 1'b0;
                     inst_valid <= 1'b1;
                  end
               end else if (bus.flush_i) begin
                  state <= DRAIN;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wdog == WDOG_LAST) begin
                  state        <= HOLD;
                  inst         <= NOP_INST;
                  inst_pc      <= addr;
                  err          <= 1'b1;
                  misalign     <= 1'b0;
                  inst_valid   <= 1'b1;
                  late_pending <= 1'b1;
               end else begin
                  wdog <= wdog + 8'd1;
               end
`endif
            end

            DRAIN: begin
               if (bus.mem_resp_valid_i) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            HOLD: begin
               // Flush and consumption both retire the held instruction.
               if (bus.flush_i || bus.inst_ready_i) begin
                  state      <= IDLE;
                  inst_valid <= 1'b0;
                  err        <= 1'b0;
                  misalign   <= 1'b0;
                  busy       <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               req_valid  <= 1'b0;
               inst_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req_valid_o  = req_valid;
   assign bus.mem_req_addr_o   = {addr[ADDR_W-1:2], 2'b00};
   assign bus.inst_valid_o     = inst_valid;
   assign bus.inst_o           = inst;
   assign bus.inst_pc_o        = inst_pc;
   assign bus.fetch_err_o      = err;
   assign bus.fetch_misalign_o = misalign;
   assign bus.busy_o           = busy;

endmodule

// File: tb/tb_ysyx_22040237_ifu_fetch_ctrl.sv
// Directed bench for the fetch controller: transaction-level scoreboard of expected
// requests and delivered instructions, plus literal latency/value checks.
`timescale 1ns/1ps
module tb_ysyx_22040237_ifu_fetch_ctrl;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        err;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_22040237_ifu_fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

   ysyx_22040237_ifu_fetch_ctrl #(
      .ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   exp_t        exp_q[$];
   logic [31:0] req_q[$];
   int          total, bad, cyc, c0, t_cons, n;
   int          first_req, first_inst, hold_cnt, req_cyc_cnt;
   logic [31:0] last_inst, last_pc;
   logic        last_err, last_mis;
   logic        prev_req_pend;
   logic        pend;
   int          cnt, cfg_delay;
   logic [31:0] cfg_data, r_data;
   logic        cfg_err, r_err;

   function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                               input logic e, input logic m);
      exp_t r;
      r.inst = i; r.pc = p; r.err = e; r.mis = m;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Scoreboard pass, run mid-cycle on every clock.
   task automatic check_cycle();
      if (rst) begin
         prev_req_pend = 1'b0;
         return;
      end
      if (req_q.size() == 0) begin
         chk("no_req", 32'(bus.mem_req_valid_o), 32'd0);
      end else if (bus.mem_req_valid_o) begin
         chk("req_addr", bus.mem_req_addr_o, req_q[0]);
         if (first_req < 0) first_req = cyc;
         req_cyc_cnt++;
         if (bus.mem_req_ready_i) void'(req_q.pop_front());
      end
      if (prev_req_pend) chk("req_held", 32'(bus.mem_req_valid_o), 32'd1);
      prev_req_pend = bus.mem_req_valid_o && !bus.mem_req_ready_i;

      if (exp_q.size() == 0) begin
         chk("no_inst", 32'(bus.inst_valid_o), 32'd0);
      end else if (bus.inst_valid_o) begin
         if (first_inst < 0) first_inst = cyc;
         chk("inst", bus.inst_o, exp_q[0].inst);
         chk("inst_pc", bus.inst_pc_o, exp_q[0].pc);
         chk("fetch_err", 32'(bus.fetch_err_o), 32'(exp_q[0].err));
         chk("fetch_misalign", 32'(bus.fetch_misalign_o), 32'(exp_q[0].mis));
         if (!bus.inst_ready_i) begin
            hold_cnt++;
         end else if (!bus.flush_i) begin
            last_inst = bus.inst_o;
            last_pc   = bus.inst_pc_o;
            last_err  = bus.fetch_err_o;
            last_mis  = bus.fetch_misalign_o;
            void'(exp_q.pop_front());
         end
      end
   endtask

   // One clock: check, then play the memory responder for the next cycle.
   task automatic step();
      logic hs;
      @(negedge clk);
      check_cycle();
      hs = bus.mem_req_valid_o && bus.mem_req_ready_i;
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_data_i  = '0;
      bus.mem_resp_err_i   = 1'b0;
      if (hs) begin
         pend   = 1'b1;
         cnt    = cfg_delay;
         r_data = cfg_data;
         r_err  = cfg_err;
      end
      if (pend) begin
         if (cnt == 0) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = r_data;
            bus.mem_resp_err_i   = r_err;
            pend = 1'b0;
         end else begin
            cnt--;
         end
      end
   endtask

   task automatic issue(input logic [31:0] pc);
      bus.pc_i       = pc;
      bus.pc_valid_i = 1'b1;
      c0             = cyc;
      first_req      = -1;
      first_inst     = -1;
      step();
      bus.pc_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((bus.busy_o || bus.inst_valid_o || pend || bus.mem_resp_valid_i) && k < 200) begin
         step();
         k++;
      end
      if (k >= 200) begin
         total++;
         bad++;
         $display("FAIL %s: still busy after %0d cycles", name, k);
      end
      step();
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; c0 = 0; t_cons = 0; n = 0;
      first_req = -1; first_inst = -1; hold_cnt = 0; req_cyc_cnt = 0;
      last_inst = '0; last_pc = '0; last_err = 1'b0; last_mis = 1'b0;
      prev_req_pend = 1'b0; pend = 1'b0; cnt = 0;
      cfg_delay = 0; cfg_data = '0; cfg_err = 1'b0; r_data = '0; r_err = 1'b0;
      bus.pc_i = '0; bus.pc_valid_i = 1'b0; bus.flush_i = 1'b0;
      bus.mem_req_ready_i = 1'b1; bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_data_i = '0; bus.mem_resp_err_i = 1'b0;
      bus.inst_ready_i = 1'b1;

      // Reset state
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
      chk("rst_req_addr", bus.mem_req_addr_o, 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
      chk("rst_inst", bus.inst_o, 32'h00000013);
      chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
      chk("rst_err", 32'(bus.fetch_err_o), 32'd0);
      chk("rst_mis", 32'(bus.fetch_misalign_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);

      // Zero-wait fetch
      cfg_data = 32'h00100093; cfg_err = 1'b0; cfg_delay = 0;
      req_q.push_back(32'h80000000);
      exp_q.push_back(mk(32'h00100093, 32'h80000000, 1'b0, 1'b0));
      issue(32'h80000000);
      wait_idle("t1_idle");
      chk("t1_req_lat", 32'(first_req - c0), 32'd1);
      chk("t1_inst_lat", 32'(first_inst - c0), 32'd3);
      chk("t1_inst", last_inst, 32'h00100093);
      chk("t1_pc", last_pc, 32'h80000000);
      chk("t1_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure, then next request two cycles after consumption
      bus.inst_ready_i = 1'b0;
      cfg_data = 32'h00208113;
      req_q.push_back(32'h80000004);
      exp_q.push_back(mk(32'h00208113, 32'h80000004, 1'b0, 1'b0));
      issue(32'h80000004);
      n = 0;
      while (!bus.inst_valid_o && n < 20) begin step(); n++; end
      chk("t2_valid_seen", 32'(bus.inst_valid_o), 32'd1);
      hold_cnt = 0;
      repeat (5) step();
      chk("t2_hold_cycles", 32'(hold_cnt), 32'd5);
      bus.inst_ready_i = 1'b1;
      t_cons = cyc;
      step();
      cfg_data = 32'h00308193;
      req_q.push_back(32'h80000008);
      exp_q.push_back(mk(32'h00308193, 32'h80000008, 1'b0, 1'b0));
      bus.pc_i = 32'h80000008;
      bus.pc_valid_i = 1'b1;
      first_req = -1;
      step();
      bus.pc_valid_i = 1'b0;
      wait_idle("t2_idle");
      chk("t2_next_req", 32'(first_req - t_cons), 32'd2);
      chk("t2_next_inst", last_inst, 32'h00308193);

      // Flush in WAIT, late response discarded
      cfg_data = 32'hdeadbeef; cfg_delay = 4;
      req_q.push_back(32'h8000000c);
      issue(32'h8000000c);
      step();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      wait_idle("t3_idle");
      chk("t3_busy", 32'(bus.busy_o), 32'd0);
      cfg_data = 32'h00408213; cfg_delay = 0;
      req_q.push_back(32'h80000010);
      exp_q.push_back(mk(32'h00408213, 32'h80000010, 1'b0, 1'b0));
      issue(32'h80000010);
      wait_idle("t3_next_idle");
      chk("t3_next_inst", last_inst, 32'h00408213);
      chk("t3_next_pc", last_pc, 32'h80000010);

      // Flush during a stalled request
      cfg_data = 32'hcafef00d; cfg_delay = 1;
      req_q.push_back(32'h80000014);
      bus.mem_req_ready_i = 1'b0;
      req_cyc_cnt = 0;
      issue(32'h80000014);
      step();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      step();
      bus.mem_req_ready_i = 1'b1;
      wait_idle("t4_idle");
      chk("t4_req_cycles", 32'(req_cyc_cnt), 32'd4);
      chk("t4_req_gone", 32'(req_q.size()), 32'd0);

      // Misaligned pc
      exp_q.push_back(mk(NOP, 32'h80000002, 1'b0, 1'b1));
      issue(32'h80000002);
      wait_idle("t5_idle");
      chk("t5_inst_lat", 32'(first_inst - c0), 32'd1);
      chk("t5_inst", last_inst, 32'h00000013);
      chk("t5_mis", 32'(last_mis), 32'd1);

      // Bus error
      cfg_data = 32'h12345678; cfg_err = 1'b1; cfg_delay = 0;
      req_q.push_back(32'h80000018);
      exp_q.push_back(mk(NOP, 32'h80000018, 1'b1, 1'b0));
      issue(32'h80000018);
      wait_idle("t6_idle");
      chk("t6_inst", last_inst, 32'h00000013);
      chk("t6_err", 32'(last_err), 32'd1);
      cfg_err = 1'b0;

      // Reset while waiting; the response then lands in IDLE and is ignored
      cfg_data = 32'h0badf00d; cfg_delay = 2;
      req_q.push_back(32'h80000020);
      issue(32'h80000020);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_idle("t7_idle");
      chk("t7_busy", 32'(bus.busy_o), 32'd0);
      cfg_data = 32'h00610313; cfg_delay = 0;
      req_q.push_back(32'h80000024);
      exp_q.push_back(mk(32'h00610313, 32'h80000024, 1'b0, 1'b0));
      issue(32'h80000024);
      wait_idle("t7_next_idle");
      chk("t7_next_inst", last_inst, 32'h00610313);

`ifdef FETCH_TIMEOUT_EN
      // Watchdog: timeout after 8 WAIT cycles, late answer at cycle 20 swallowed
      cfg_data = 32'hbad0bad0; cfg_delay = 18;
      req_q.push_back(32'h80000030);
      exp_q.push_back(mk(NOP, 32'h80000030, 1'b1, 1'b0));
      issue(32'h80000030);
      while (cyc < c0 + 12) step();
      cfg_data = 32'h00710393; cfg_delay = 0;
      req_q.push_back(32'h80000034);
      exp_q.push_back(mk(32'h00710393, 32'h80000034, 1'b0, 1'b0));
      bus.pc_i = 32'h80000034;
      bus.pc_valid_i = 1'b1;
      n = 0;
      while (!bus.mem_req_valid_o && n < 40) begin step(); n++; end
      bus.pc_valid_i = 1'b0;
      chk("t8_err_lat", 32'(first_inst - c0), 32'd10);
      chk("t8_req_after_late", 32'(cyc - c0), 32'd22);
      wait_idle("t8_idle");
      chk("t8_next_inst", last_inst, 32'h00710393);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "bench stopped by time limit");
   end

endmodule

// File: doc/ysyx_22040237_ifu_fetch_ctrl.md
Name: ysyx_22040237_ifu_fetch_ctrl

Overview:
Multi-cycle instruction fetch controller that sits directly upstream of the single-cycle core's inst_in.
- Takes the current pc from the pc register.
- Issues a read on a valid/ready instruction-memory port and waits for the response.
- Holds the fetched instruction valid until the core consumes it.
- Handles redirect flushes, misaligned pc and bus errors, so the core never sees a torn or stale instruction.

Parameters:
ADDR_W, 32, pc / memory address width
INST_W, 32, instruction width
NOP_INST, 32'h00000013, instruction substituted on fault (addi x0,x0,0)
TIMEOUT_CYC, 255, response watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_i  in  ADDR_W  fetch address from pc register
pc_valid_i  in  1  pc_i holds a new address to fetch
flush_i  in  1  redirect; discard in-flight and held instruction
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_W  request address, word aligned
mem_resp_valid_i  in  1  read data valid (always accepted, no backpressure)
mem_resp_data_i  in  INST_W  read data
mem_resp_err_i  in  1  bus error qualifying mem_resp_valid_i
inst_valid_o  out  1  inst_o / inst_pc_o valid to core
inst_o  out  INST_W  fetched instruction
inst_pc_o  out  ADDR_W  pc of inst_o
inst_ready_i  in  1  core consumes instruction
fetch_err_o  out  1  qualifies inst_valid_o: bus error or timeout, inst_o = NOP_INST
fetch_misalign_o  out  1  qualifies inst_valid_o: pc_i[1:0] != 0, inst_o = NOP_INST
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE.
  - All outputs 0 except inst_o = NOP_INST.
  - Internal address, drop flag and watchdog cleared.
  - rst mid-transaction abandons the transaction. A response arriving after reset while in IDLE is ignored.
- States: IDLE, REQ, WAIT, DRAIN, HOLD. All outputs are registered from state and captured data.
- IDLE:
  - pc_valid_i=1 and flush_i=0 with pc_i[1:0]==0: latch pc_i into addr, go to REQ.
  - Misaligned pc: latch pc_i, inst_o=NOP_INST, set fetch_misalign_o, go to HOLD. No memory request is issued.
- REQ:
  - mem_req_valid_o=1 and mem_req_addr_o=addr, both stable until mem_req_ready_i.
  - A request is never withdrawn.
  - Handshake: go to WAIT, or to DRAIN if flush_i seen in REQ or in the handshake cycle. A flush is remembered by a drop flag.
- WAIT:
  - On mem_resp_valid_i: capture data (NOP_INST and fetch_err_o if mem_resp_err_i), inst_pc_o=addr, go to HOLD.
  - flush_i without response: go to DRAIN.
  - flush_i in the same cycle as mem_resp_valid_i: discard response, go to IDLE.
- DRAIN: wait for mem_resp_valid_i, discard data and err, go to IDLE. flush_i has no further effect.
- HOLD:
  - inst_valid_o=1; inst_o, inst_pc_o and flags stable while inst_ready_i=0.
  - inst_valid_o and inst_ready_i both high: go to IDLE, clear flags.
  - flush_i: go to IDLE, drop instruction. Flush wins over a simultaneous ready.
- Latency, zero-wait memory (ready in REQ, response the next cycle):
  - pc_valid_i at cycle 0, mem_req_valid_o at cycle 1, response at cycle 2, inst_valid_o at cycle 3.
  - The earliest next request after consumption is 2 cycles later (IDLE then REQ).
- At most one outstanding request. mem_resp_valid_i in IDLE, REQ or HOLD is ignored, except as stated under the optional feature.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog counts cycles in WAIT and resets on entry to WAIT.
  - Reaching TIMEOUT_CYC: go to HOLD with inst_o=NOP_INST and fetch_err_o=1, set a late_pending flag.
  - While late_pending is set, the first mem_resp_valid_i in any state is discarded and clears the flag.
  - While late_pending is set, no new request is issued: IDLE waits.
  - rst clears the watchdog and late_pending.
- Undefined: no watchdog; WAIT and DRAIN wait indefinitely.

Test Plan:
- Zero-wait fetch: pc_i=0x80000000, resp data 0x00100093, inst_ready_i=1 -> inst_valid_o at cycle 3, inst_o=0x00100093, inst_pc_o=0x80000000, then IDLE.
- Backpressure: inst_ready_i low 5 cycles after inst_valid_o -> inst_o, inst_pc_o and flags stable 5 cycles, consumed on cycle 6, then mem_req_valid_o 2 cycles later for the next pc.
- Flush in WAIT: flush_i 1 cycle after request accepted, response data 0xdeadbeef 4 cycles later -> inst_valid_o never asserts for it, return to IDLE, next pc 0x80000010 fetched normally.
- Flush during REQ stall: mem_req_ready_i low 3 cycles, flush_i on cycle 2 -> request stays valid with the same addr until accepted, then DRAIN, response discarded.
- Faults:
  - pc_i=0x80000002 -> no mem request; inst_valid_o with inst_o=0x00000013 and fetch_misalign_o=1.
  - mem_resp_err_i=1 -> inst_o=0x00000013, fetch_err_o=1.
- FETCH_TIMEOUT_EN with TIMEOUT_CYC=8: no response -> after 8 WAIT cycles inst_valid_o with fetch_err_o=1. A late response at cycle 20 is discarded, and only then is the next request issued.
